input_packer: RTL
=================

# input_packer

Upstream message stage between the chip's byte-serial input pins and the AES/SHA3 datapath. It collects the byte stream presented while `i_start` is high and latches the mode on the first byte. It then builds one rate-width block: SHA3 pad10*1 for hash mode, zero-fill for AES modes. The block is handed to the core over a valid/ready handshake, and the packer holds it until the core accepts it.

## Interface
- `RATE_BYTES`, 136: output block width in bytes (SHA3-256 rate).
- `MAX_BYTES`, 16: maximum accepted message bytes; legal range 1..RATE_BYTES-1.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_data` in 8: message byte, sampled on every edge where `i_start`=1.
- `i_mode` in 2: 00 SHA3-256, 01 AES-128 encrypt, 10 AES-128 decrypt, 11 reserved; sampled only on the first `i_start` edge.
- `i_start` in 1: high for exactly the message bytes, contiguous.
- `i_ready` in 1: core accepts the block.
- `o_block` out RATE_BYTES*8: packed block; byte k at bits [8k+7:8k]; first received byte is byte 0.
- `o_len` out 8: number of stored message bytes.
- `o_mode` out 2: latched mode.
- `o_valid` out 1: block available.
- `o_overflow` out 1: more than MAX_BYTES bytes were offered.
- `o_busy` out 1: state is not IDLE.

## Operation
- States: IDLE, COLLECT, PAD, HOLD.
- IDLE, `i_start`=1:
  - clear buffer to zero, write `i_data` to byte 0;
  - `cnt`=1, latch `i_mode`, clear overflow;
  - go to COLLECT.
- COLLECT, `i_start`=1:
  - if `cnt`<MAX_BYTES, write byte `cnt` and increment `cnt`;
  - else discard the byte and set overflow (sticky until next IDLE exit).
- COLLECT, `i_start`=0: go to PAD.
- PAD (one cycle):
  - mode 00: byte[`cnt`] |= 0x06, byte[RATE_BYTES-1] |= 0x80. When `cnt`=RATE_BYTES-1 this yields 0x86 in one byte.
  - modes 01/10/11: no change; bytes ≥`cnt` stay zero.
  - go to HOLD.
- HOLD: `o_valid`=1. On `o_valid` & `i_ready`, go to IDLE. Buffer contents remain until the next message starts.
- `i_start` in PAD or HOLD is ignored; bytes are lost. Upstream must wait for `o_busy`=0.
- `cnt` is 8 bits wide and saturates at MAX_BYTES.
- Buffer write index is `cnt` directly; no wrap-around.
- `o_len`=`cnt`.

## Timing
- Reset values:
  - state IDLE;
  - `o_block`=0, `o_len`=0, `o_mode`=00;
  - `o_valid`=0, `o_overflow`=0, `o_busy`=0.
- Reset takes effect immediately, mid-operation included. `o_valid` drops without waiting for a clock.
- Byte capture latency: 0. Byte sampled at edge e is in the buffer after e.
- Edge f is the first edge sampling `i_start`=0 in COLLECT:
  - after edge f, state is PAD;
  - after edge f+1, state is HOLD and `o_valid`=1.
- Handshake:
  - `o_block`, `o_len`, `o_mode` and `o_overflow` are stable while `o_valid`=1 and not yet accepted.
  - Transfer happens on the edge where both `o_valid` and `i_ready` are 1. `o_valid` is low after that edge.
  - `i_ready` may be high early. Minimum HOLD duration is 1 cycle.
- `o_busy` is registered and is high from the edge after the first byte through the accepting edge.
- Back-to-back: the earliest next first-byte edge is the edge after acceptance.

## Structure
- Shared package `aes_sha3_pkg` holds:
  - mode encodings `MODE_SHA3`, `MODE_AES_ENC`, `MODE_AES_DEC`, `MODE_RSVD`;
  - the state enum;
  - `SHA3_DS_PAD`=0x06 and `SHA3_END_PAD`=0x80.
- Single module; no sub-module.
- The buffer is a flat register with a byte-enable decode from `cnt`.

## Test plan
- Mode 00, 14 bytes 0x00..0x0D:
  - byte0..13 = 00..0D, byte14=0x06, byte135=0x80, rest 0;
  - `o_len`=14, `o_mode`=00;
  - `o_valid` high 2 edges after `i_start` falls.
- Mode 01, 14 bytes 0xA0..0xAD, `i_ready`=1:
  - bytes 0..13 = A0..AD, all others 0, `o_len`=14;
  - `o_valid` high exactly 1 cycle.
- MAX_BYTES=135 build, mode 00, 135 bytes of 0x11: byte134=0x11, byte135=0x86, `o_len`=135.
- Overflow: 18 bytes 0x01..0x12 with MAX_BYTES=16:
  - `o_len`=16, `o_overflow`=1;
  - byte15=0x10, byte16=0x06 (mode 00).
- Backpressure: hold `i_ready`=0 for 5 cycles in HOLD and pulse `i_start` with 0xFF:
  - `o_block` unchanged, `o_valid` stays 1;
  - acceptance on the edge where `i_ready` rises;
  - `o_busy` falls after that edge.
- Reset mid-COLLECT after 7 bytes, then a new 14-byte mode 10 message:
  - all outputs 0 immediately on reset;
  - second block contains only the new bytes, `o_len`=14, `o_mode`=10.

Source files
------------

// File: rtl/aes_sha3_pkg.sv
// Shared definitions for the AES/SHA3 front end: mode codes, packer states
// and the SHA3 padding constants.
package aes_sha3_pkg;

  localparam logic [1:0] MODE_SHA3    = 2'b00;
  localparam logic [1:0] MODE_AES_ENC = 2'b01;
  localparam logic [1:0] MODE_AES_DEC = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  localparam logic [7:0] SHA3_DS_PAD  = 8'h06;
  localparam logic [7:0] SHA3_END_PAD = 8'h80;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PAD     = 2'd2,
    HOLD    = 2'd3
  } packer_state_t;

endpackage

// File: rtl/input_packer_if.sv
// Byte-serial message input and block output handshake of the input packer.
// slave = packer side, master = upstream pins / core side.
interface input_packer_if #(
  parameter int RATE_BYTES = 136
);
  logic [7:0]              i_data;
  logic [1:0]              i_mode;
  logic                    i_start;
  logic                    i_ready;
  logic [RATE_BYTES*8-1:0] o_block;
  logic [7:0]              o_len;
  logic [1:0]              o_mode;
  logic                    o_valid;
  logic                    o_overflow;
  logic                    o_busy;

  modport master (
    output i_data, i_mode, i_start, i_ready,
    input  o_block, o_len, o_mode, o_valid, o_overflow, o_busy
  );

  modport slave (
    input  i_data, i_mode, i_start, i_ready,
    output o_block, o_len, o_mode, o_valid, o_overflow, o_busy
  );
endinterface

// File: rtl/input_packer.sv
// Collects a byte-serial message into one rate-width block, applies SHA3
// pad10*1 (hash mode) or leaves zero fill (AES modes), and holds the block
// on a valid/ready handshake until the core takes it.
//
// state   | meaning
// IDLE    | waiting for the first byte (i_start high)
// COLLECT | storing bytes while i_start stays high
// PAD     | one cycle applying SHA3 padding when mode is hash
// HOLD    | block presented with o_valid, waiting for i_ready
module input_packer
  import aes_sha3_pkg::*;
#(
  parameter int RATE_BYTES = 136,
  parameter int MAX_BYTES  = 16
) (
  input logic             clk,
  input logic             rst_n,
  input_packer_if.slave   bus
);

  localparam int         BW       = RATE_BYTES * 8;
  localparam logic [7:0] MAX_CNT  = 8'(MAX_BYTES);

  packer_state_t state_q, state_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic          ovf_q, ovf_d;
  logic          busy_q;

  // State register; reset drops o_valid immediately since it decodes HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_start)  state_d = COLLECT;
      COLLECT: if (!bus.i_start) state_d = PAD;
      PAD:                       state_d = HOLD;
      HOLD:    if (bus.i_ready)  state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    bus.o_valid = (state_q == HOLD);
  end

  // Busy flag registered from the next state so it tracks state != IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= 1'b0;
    else        busy_q <= (state_d != IDLE);
  end

  // Buffer update: byte-enable decode from cnt while collecting, padding in PAD.
  // Both pad ORs land in the same byte when cnt == RATE_BYTES-1, giving 0x86.
  always_comb begin
    blk_d  = blk_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    ovf_d  = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          blk_d      = '0;
          blk_d[7:0] = bus.i_data;
          cnt_d      = 8'd1;
          mode_d     = bus.i_mode;
          ovf_d      = 1'b0;
        end
      end
      COLLECT: begin
        if (bus.i_start) begin
          if (cnt_q < MAX_CNT) begin
            for (int k = 0; k < RATE_BYTES; k++) begin
              if (cnt_q == 8'(k)) blk_d[8*k +: 8] = bus.i_data;
            end
            cnt_d = cnt_q + 8'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      PAD: begin
        if (mode_q == MODE_SHA3) begin
          for (int k = 0; k < RATE_BYTES; k++) begin
            if (cnt_q == 8'(k)) blk_d[8*k +: 8] = blk_d[8*k +: 8] | SHA3_DS_PAD;
          end
          blk_d[BW-1 -: 8] = blk_d[BW-1 -: 8] | SHA3_END_PAD;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; contents persist in HOLD and after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q  <= '0;
      cnt_q  <= 8'd0;
      mode_q <= MODE_SHA3;
      ovf_q  <= 1'b0;
    end else begin
      blk_q  <= blk_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.o_block    = blk_q;
  assign bus.o_len      = cnt_q;
  assign bus.o_mode     = mode_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_busy     = busy_q;

endmodule
